// File: rtl/f_writeback_stage_if.sv
// ----------------------------------------------------------------------------
// f_writeback_stage_if
// Groups the write-back stage's bus signals:
//   fpu_*  : FPU result channel (valid/ready handshake)
//   ld_*   : FP load return channel (valid only, no backpressure)
//   rf_*   : FP register-file write port
// Modports:
//   master : producer of FPU results and loads, consumer of the rf write port
//   slave  : the write-back stage itself
// ----------------------------------------------------------------------------
interface f_writeback_stage_if #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
);
  localparam int RD_W = $clog2(NUM_REGS);

  logic              fpu_valid;
  logic              fpu_ready;
  logic [RD_W-1:0]   fpu_rd;
  logic [DATA_W-1:0] fpu_result;
  logic [4:0]        fpu_flags;

  logic              ld_valid;
  logic [RD_W-1:0]   ld_rd;
  logic [DATA_W-1:0] ld_data;

  logic              rf_wen;
  logic [RD_W-1:0]   rf_rd;
  logic [DATA_W-1:0] rf_wdata;

  modport master (
    output fpu_valid, fpu_rd, fpu_result, fpu_flags,
    output ld_valid, ld_rd, ld_data,
    input  fpu_ready,
    input  rf_wen, rf_rd, rf_wdata
  );

  modport slave (
    input  fpu_valid, fpu_rd, fpu_result, fpu_flags,
    input  ld_valid, ld_rd, ld_data,
    output fpu_ready,
    output rf_wen, rf_rd, rf_wdata
  );
endinterface

// File: rtl/f_writeback_stage.sv
// ----------------------------------------------------------------------------
// f_writeback_stage
// FP write-back stage feeding the FP register file write port. FP load data
// (never back-pressured) has top priority; FPU results are buffered in a
// small FIFO and drained whenever no load is returning. Also keeps a
// per-register busy scoreboard and the sticky fcsr.fflags accumulator.
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   issue_valid_i   FP op with FP destination issued this cycle
//   issue_rd_i      destination of the issued op
//   busy_mask_o     bit i set: write to register i still pending
//   fflags_clr_i    CSR write clears fflags
//   fflags_o        sticky {NV,DZ,OF,UF,NX}
//   wb_if (slave)   FPU channel, load channel, register-file write port
//
// Optional feature (macro F_WB_BYPASS_EN): an FPU result accepted while the
// FIFO is empty and no load is returning skips the FIFO and is written with
// one-cycle latency. Without the macro every FPU result goes through the FIFO.
// ----------------------------------------------------------------------------
module f_writeback_stage #(
  parameter int NUM_REGS   = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        issue_valid_i,
  input  logic [$clog2(NUM_REGS)-1:0] issue_rd_i,
  output logic [NUM_REGS-1:0]         busy_mask_o,
  input  logic                        fflags_clr_i,
  output logic [4:0]                  fflags_o,
  f_writeback_stage_if.slave          wb_if
);
  localparam int RD_W  = $clog2(NUM_REGS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
    logic [4:0]        flags;
  } wb_entry_t;

  wb_entry_t         fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              rf_wen_q, rf_wen_d;
  logic [RD_W-1:0]   rf_rd_q, rf_rd_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [4:0]        fflags_q, fflags_d;

  wb_entry_t         fpu_in;
  wb_entry_t         head;
  logic              fpu_accept;
  logic              bypass;
  logic              fifo_push;
  logic              fifo_pop;

  // Ready depends only on the registered count, so there is no combinational
  // path from fpu_valid or ld_valid; a pop does not free a slot until the
  // following cycle.
  assign wb_if.fpu_ready = (count_q < CNT_W'(FIFO_DEPTH));
  assign fpu_accept      = wb_if.fpu_valid && wb_if.fpu_ready;
  assign fpu_in          = '{rd: wb_if.fpu_rd, data: wb_if.fpu_result, flags: wb_if.fpu_flags};
  assign head            = fifo_mem[rd_ptr_q];

`ifdef F_WB_BYPASS_EN
  assign bypass = fpu_accept && (count_q == '0) && !wb_if.ld_valid;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which is what keeps this block from inferring latches.
    rf_wen_d   = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    fflags_d   = fflags_clr_i ? 5'b0 : fflags_q;
    busy_d     = busy_q;
    fifo_push  = fpu_accept && !bypass;
    fifo_pop   = 1'b0;

    if (wb_if.ld_valid) begin
      rf_wen_d   = 1'b1;
      rf_rd_d    = wb_if.ld_rd;
      rf_wdata_d = wb_if.ld_data;
    end else if (count_q != '0) begin
      fifo_pop   = 1'b1;
      rf_wen_d   = 1'b1;
      rf_rd_d    = head.rd;
      rf_wdata_d = head.data;
      fflags_d   = fflags_d | head.flags;
    end else if (bypass) begin
      rf_wen_d   = 1'b1;
      rf_rd_d    = fpu_in.rd;
      rf_wdata_d = fpu_in.data;
      fflags_d   = fflags_d | fpu_in.flags;
    end

    // Clear first, then set, so an issue to the same rd at this edge wins.
    if (rf_wen_d)      busy_d[rf_rd_d]    = 1'b0;
    if (issue_valid_i) busy_d[issue_rd_i] = 1'b1;

    // Power-of-two depth: pointers wrap by natural overflow.
    wr_ptr_d = fifo_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = fifo_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rf_wen_q   <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
      fflags_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rf_wen_q   <= rf_wen_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
      fflags_q   <= fflags_d;
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; emptying it only needs
  // the pointers and count cleared, and stale slots are never read.
  always_ff @(posedge CLK) begin
    if (fifo_push) fifo_mem[wr_ptr_q] <= fpu_in;
  end

  assign wb_if.rf_wen   = rf_wen_q;
  assign wb_if.rf_rd    = rf_rd_q;
  assign wb_if.rf_wdata = rf_wdata_q;
  assign busy_mask_o    = busy_q;
  assign fflags_o       = fflags_q;
endmodule

// File: tb/tb_f_writeback_stage.sv
// ----------------------------------------------------------------------------
// tb_f_writeback_stage
// Self-checking bench for f_writeback_stage: directed scenarios followed by
// randomized traffic, all compared each cycle against a queue-based
// reference model of the write-back rules.
// ----------------------------------------------------------------------------
module tb_f_writeback_stage;
  localparam int NUM_REGS = 32;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 2;
`ifdef F_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                CLK = 1'b0;
  logic                RST;
  logic                issue_valid;
  logic [4:0]          issue_rd;
  logic [NUM_REGS-1:0] busy_mask;
  logic                fflags_clr;
  logic [4:0]          fflags;

  f_writeback_stage_if #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) wb_if ();

  f_writeback_stage #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .issue_valid_i(issue_valid),
    .issue_rd_i   (issue_rd),
    .busy_mask_o  (busy_mask),
    .fflags_clr_i (fflags_clr),
    .fflags_o     (fflags),
    .wb_if        (wb_if)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending FPU results as a queue, architectural outputs
  // as plain variables.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  flags;
  } ent_t;

  ent_t                q[$];
  logic                m_wen   = 1'b0;
  logic [4:0]          m_rd    = '0;
  logic [31:0]         m_data  = '0;
  logic [NUM_REGS-1:0] m_busy  = '0;
  logic [4:0]          m_flags = '0;

  task automatic model_edge();
    bit         acc;
    bit         fsel;
    logic [4:0] fl;
    ent_t       e;
    if (RST) begin
      q.delete();
      m_wen = 0; m_rd = 0; m_data = 0; m_busy = 0; m_flags = 0;
    end else begin
      acc  = wb_if.fpu_valid && (q.size() < DEPTH);
      m_wen = 0; fsel = 0; fl = 0;
      if (wb_if.ld_valid) begin
        m_wen = 1; m_rd = wb_if.ld_rd; m_data = wb_if.ld_data;
      end else if (q.size() != 0) begin
        e = q.pop_front();
        m_wen = 1; m_rd = e.rd; m_data = e.data; fsel = 1; fl = e.flags;
      end else if (BYP && acc) begin
        m_wen = 1; m_rd = wb_if.fpu_rd; m_data = wb_if.fpu_result;
        fsel = 1; fl = wb_if.fpu_flags; acc = 0;
      end
      if (acc) q.push_back('{wb_if.fpu_rd, wb_if.fpu_result, wb_if.fpu_flags});
      if (fflags_clr) m_flags = 0;
      if (fsel) m_flags = m_flags | fl;
      if (m_wen) m_busy[m_rd] = 1'b0;
      if (issue_valid) m_busy[issue_rd] = 1'b1;
    end
  endtask

  // One clock: inputs are already set (clock low), check ready before the
  // edge, advance model at the edge, compare outputs 1ns later, return at
  // the next falling edge.
  task automatic tick();
    check("fpu_ready", wb_if.fpu_ready, (q.size() < DEPTH));
    @(posedge CLK);
    model_edge();
    #1;
    check("rf_wen",    wb_if.rf_wen,   m_wen);
    check("rf_rd",     wb_if.rf_rd,    m_rd);
    check("rf_wdata",  wb_if.rf_wdata, m_data);
    check("busy_mask", busy_mask,      m_busy);
    check("fflags",    fflags,         m_flags);
    @(negedge CLK);
  endtask

  task automatic idle();
    RST = 0; issue_valid = 0; issue_rd = 0; fflags_clr = 0;
    wb_if.fpu_valid = 0; wb_if.fpu_rd = 0; wb_if.fpu_result = 0; wb_if.fpu_flags = 0;
    wb_if.ld_valid = 0; wb_if.ld_rd = 0; wb_if.ld_data = 0;
  endtask

  task automatic send_fpu(input logic [4:0] rd, input logic [31:0] res, input logic [4:0] fl);
    wb_if.fpu_valid = 1; wb_if.fpu_rd = rd; wb_if.fpu_result = res; wb_if.fpu_flags = fl;
  endtask

  task automatic send_ld(input logic [4:0] rd, input logic [31:0] d);
    wb_if.ld_valid = 1; wb_if.ld_rd = rd; wb_if.ld_data = d;
  endtask

  initial begin
    int sent;
    idle();
    RST = 1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 0;
    check("reset_rf_wen",  wb_if.rf_wen,    0);
    check("reset_busy",    busy_mask,       0);
    check("reset_fflags",  fflags,          0);
    check("reset_ready",   wb_if.fpu_ready, 1);
    check("reset_rf_rd",   wb_if.rf_rd,     0);

    // Single load to a busy register.
    issue_valid = 1; issue_rd = 5; tick(); idle();
    send_ld(5, 32'h3F80_0000); tick(); idle();
    check("load_wen",   wb_if.rf_wen,   1);
    check("load_rd",    wb_if.rf_rd,    5);
    check("load_data",  wb_if.rf_wdata, 32'h3F80_0000);
    check("load_busy5", busy_mask[5],   0);
    tick();
    check("load_wen_drop", wb_if.rf_wen, 0);
    check("load_rd_hold",  wb_if.rf_rd,  5);

    // FPU latency.
    issue_valid = 1; issue_rd = 3; tick(); idle();
    check("lat_busy3_set", busy_mask[3], 1);
    send_fpu(3, 32'h4049_0FDB, 5'b00001); tick(); idle();
    check("lat_wen_e0", wb_if.rf_wen, BYP);
    tick();
    check("lat_wen_e1", wb_if.rf_wen, !BYP);
    check("lat_rd",     wb_if.rf_rd,    3);
    check("lat_data",   wb_if.rf_wdata, 32'h4049_0FDB);
    check("lat_flags",  fflags,         5'b00001);
    check("lat_busy3",  busy_mask[3],   0);

    // Backpressure: 4 loads held while 3 FPU results are offered.
    sent = 0;
    for (int c = 0; c < 10; c++) begin
      idle();
      if (c < 4) send_ld(5'(20 + c), 32'hA000_0000 + c);
      if (sent < 3) send_fpu(5'(10 + sent), 32'hB000_0000 + sent, 5'b0);
      if (c >= 2 && c <= 4) check("bp_ready_low", wb_if.fpu_ready, 0);
      if (c == 5)           check("bp_ready_back", wb_if.fpu_ready, 1);
      if (wb_if.fpu_valid && q.size() < DEPTH) sent++;
      tick();
    end
    idle();
    check("bp_all_sent", sent, 3);

    // Flag clear colliding with an accumulate.
    fflags_clr = 1; tick(); idle();
    send_fpu(9, 32'h1, 5'b10000); tick(); idle(); tick(); tick();
    check("clr_pre", fflags, 5'b10001 & 5'b10000);
    send_fpu(10, 32'h2, 5'b00100);
    if (BYP) fflags_clr = 1;
    tick(); idle();
    if (!BYP) begin fflags_clr = 1; tick(); idle(); end
    check("clr_collide", fflags, 5'b00100);

    // Scoreboard set/clear collision.
    issue_valid = 1; issue_rd = 7; send_ld(7, 32'h7); tick(); idle();
    check("sb_collide", busy_mask[7], 1);

    // Reset with two entries queued and registers busy.
    issue_valid = 1; issue_rd = 12; send_ld(1, 32'h11); send_fpu(2, 32'h22, 5'b01000); tick();
    issue_rd = 13; send_ld(1, 32'h12); send_fpu(4, 32'h44, 5'b00010); tick(); idle();
    check("rst_fifo_full", wb_if.fpu_ready, 0);
    RST = 1; tick(); idle();
    check("rst_mid_wen",   wb_if.rf_wen,    0);
    check("rst_mid_busy",  busy_mask,       0);
    check("rst_mid_flags", fflags,          0);
    check("rst_mid_ready", wb_if.fpu_ready, 1);
    repeat (3) begin
      tick();
      check("rst_no_stale", wb_if.rf_wen, 0);
    end

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      idle();
      RST         = ($urandom_range(0, 199) == 0);
      issue_valid = ($urandom_range(0, 9) < 3);
      issue_rd    = 5'($urandom);
      fflags_clr  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) send_ld(5'($urandom), $urandom);
      if ($urandom_range(0, 1) == 0) send_fpu(5'($urandom), $urandom, 5'($urandom));
      tick();
    end
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/f_writeback_stage.md
Name: f_writeback_stage

Overview:
- Write-back stage directly upstream of the FP register file; sole source of its write port (wen/rd/data).
- Merges multi-cycle FPU results (valid/ready, buffered in a small FIFO) with FP load data (no backpressure, top priority).
- Keeps a per-register busy scoreboard for issue-side hazard checks.
- Accumulates sticky IEEE exception flags for fcsr.fflags.

Parameters:
NUM_REGS, 32, FP register count; rd fields are $clog2(NUM_REGS) bits
DATA_W, 32, FP data width
FIFO_DEPTH, 2, FPU result buffer entries; power of two, >=2

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  reset, synchronous, active-high
issue_valid  in  1  FP op with an FP destination issued this cycle
issue_rd  in  5  destination of the issued op
busy_mask  out  NUM_REGS  bit i=1: write to reg i still pending
fpu_valid  in  1  FPU result available
fpu_ready  out  1  stage can accept an FPU result
fpu_rd  in  5  FPU result destination
fpu_result  in  DATA_W  FPU result data
fpu_flags  in  5  {NV,DZ,OF,UF,NX} for this result
ld_valid  in  1  FP load data returned (flw)
ld_rd  in  5  load destination
ld_data  in  DATA_W  load data
rf_wen  out  1  register-file write enable
rf_rd  out  5  register-file write index
rf_wdata  out  DATA_W  register-file write data
fflags  out  5  sticky accumulated flags
fflags_clr  in  1  CSR write clears fflags

Behaviour:
- Reset (RST high at an edge): FIFO emptied, pending entries dropped. rf_wen=0, rf_rd=0, rf_wdata=0, busy_mask=0, fflags=0. fpu_ready=1 from the first cycle after reset.
- FPU handshake accepted when fpu_valid && fpu_ready at an edge. fpu_ready = (count < FIFO_DEPTH), from registered count only; no combinational path from fpu_valid or ld_valid.
- Accepted entry {rd,result,flags} is pushed to the FIFO tail. Pointers wrap modulo FIFO_DEPTH. count is $clog2(FIFO_DEPTH)+1 bits.
- Write selection each cycle, priority order:
  - ld_valid: load selected.
  - else FIFO non-empty: head selected and popped at the edge.
  - else nothing.
- Selected write is registered: rf_wen/rf_rd/rf_wdata are valid the cycle after the selecting edge. rf_wen=0 otherwise; rf_rd/rf_wdata hold their last values.
- Latency:
  - Load: ld_valid sampled at edge E0, rf_wen=1 after E0.
  - FPU without bypass: accepted at E0, earliest rf_wen after E1.
- Push and pop in the same cycle: count unchanged. A full FIFO with a pop does not raise fpu_ready until the following cycle.
- Sustained ld_valid stalls the FIFO indefinitely. Loads are never dropped.
- Scoreboard:
  - Bit issue_rd is set at the edge when issue_valid=1.
  - Bit rf_rd is cleared at the edge after a write is launched (same edge rf_wen rises).
  - Set and clear of the same index at the same edge: set wins.
- Flags: when an FPU entry is selected for write, fflags <= fflags | entry.flags. Loads never affect flags.
  - fflags_clr at the same edge as an accumulate: fflags <= entry.flags (clear first, then OR).
- Writes to one rd leave in selection order. The issue side guarantees no two in-flight FPU ops target the same rd.

Optional Feature:
- Macro F_WB_BYPASS_EN.
- Defined: if FIFO empty and ld_valid=0 at the accepting edge, the FPU result goes straight into the output register and skips the FIFO. rf_wen=1 after E0 (1-cycle latency); flags and scoreboard update at E0.
- Undefined: every FPU result passes through the FIFO (2-cycle minimum latency).
- Ordering, priority and backpressure rules are identical either way.

Test Plan:
- Reset mid-operation: FIFO holds 2 entries, RST high for one edge -> rf_wen=0, busy_mask=0, fflags=0, fpu_ready=1; stale entries never written.
- Single load: ld_valid, ld_rd=5, ld_data=0x3F800000 -> next cycle rf_wen=1, rf_rd=5, rf_wdata=0x3F800000; busy bit 5 cleared if it was set.
- FPU latency: issue rd=3, then fpu_valid with rd=3, result=0x40490FDB, flags=5'b00001 -> rf_wen after E1 (after E0 with F_WB_BYPASS_EN); fflags=00001; busy_mask[3] 1->0.
- Backpressure: ld_valid held 4 cycles while FPU sends 3 results -> fpu_ready drops after 2 accepts; 4 load writes, then FPU writes in order; third FPU result accepted only after the first pop.
- Flag clear collision: fflags=10000, fflags_clr with an FPU write carrying flags 00100 at the same edge -> fflags=00100.
- Scoreboard collision: issue_valid rd=7 at the same edge a write to rd=7 launches -> busy_mask[7] stays 1.
